// File: rtl/serial_addsub_chunked.sv
// serial_addsub_chunked
// Wide add/subtract built around a single CHUNK-bit adder slice. Operands are
// captured on an accepted start and consumed CHUNK bits per clock, least
// significant chunk first, with the slice carry held in a register between
// chunks. The final chunk may be narrower than CHUNK; its unused upper slice
// bits see only shifted-in zeros and are never written to the result.
//
// state | meaning
// IDLE  | waiting for start; result and flags hold their last values
// RUN   | one chunk added per clock, cnt selects the result chunk
// DONE  | done pulse for one cycle; a start here is accepted as in IDLE

module serial_addsub_chunked #(
  parameter int unsigned WIDTH = 381,
  parameter int unsigned CHUNK = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  // Bits actually used in the final chunk (1..CHUNK).
  localparam int unsigned LAST   = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Low CHUNK bits set; also correct when CHUNK == WIDTH (shift clears all).
  localparam logic [WIDTH-1:0] CMASK = ~({WIDTH{1'b1}} << CHUNK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] qa_q;
  logic [WIDTH-1:0] qb_q;
  logic             cy_q;
  logic [CW-1:0]    cnt_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic [WIDTH-1:0] s_q;
  logic             carry_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [CHUNK:0]   sum_full;
  logic [WIDTH-1:0] sum_ext;
  logic [WIDTH-1:0] wmask;
  logic [31:0]      shamt;
  logic [WIDTH-1:0] s_d;
  logic             last_chunk;

  // Adder slice: low chunk of each operand plus the registered chunk carry.
  always_comb begin
    sum_full = {1'b0, qa_q[CHUNK-1:0]} + {1'b0, qb_q[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, cy_q};
  end

  // Merge the slice sum into the result at the current chunk position; the
  // WIDTH-bit shift drops any slice bits beyond the top of a partial chunk.
  always_comb begin
    shamt      = 32'(cnt_q) * CHUNK;
    sum_ext    = WIDTH'(sum_full[CHUNK-1:0]);
    wmask      = CMASK << shamt;
    s_d        = (s_q & ~wmask) | ((sum_ext << shamt) & wmask);
    last_chunk = (cnt_q == CW'(NCHUNK - 1));
  end

  // Control FSM with operand shifters and registered result/flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      qa_q    <= '0;
      qb_q    <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      s_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtract as A + ~B + 1: the +1 enters through the chunk carry.
            qa_q    <= A;
            qb_q    <= sub ? ~B : B;
            cy_q    <= sub;
            cnt_q   <= '0;
            a_msb_q <= A[WIDTH-1];
            b_msb_q <= sub ? ~B[WIDTH-1] : B[WIDTH-1];
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        RUN: begin
          qa_q  <= qa_q >> CHUNK;
          qb_q  <= qb_q >> CHUNK;
          cy_q  <= sum_full[CHUNK];
          s_q   <= s_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_chunk) begin
            // In the final chunk everything above bit LAST-1 is zero, so
            // slice bit LAST is exactly the carry out of the result's MSB.
            carry_q <= sum_full[LAST];
            ovf_q   <= (a_msb_q == b_msb_q) && (s_d[WIDTH-1] != a_msb_q);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign S        = s_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_addsub_chunked.sv
// Directed bench for serial_addsub_chunked: default 381/32 instance, a
// 64/24 instance with a partial last chunk, and an 8/8 single-chunk instance.

module tb_serial_addsub_chunked;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // Default instance (NCHUNK = 12)
  logic         start0, sub0;
  logic [380:0] a0, b0, s0;
  logic         carry0, ovf0, busy0, done0;

  // 64/24 instance (NCHUNK = 3, LAST = 16)
  logic         start1, sub1;
  logic [63:0]  a1, b1, s1;
  logic         carry1, ovf1, busy1, done1;

  // 8/8 instance (NCHUNK = 1)
  logic         start2, sub2;
  logic [7:0]   a2, b2, s2;
  logic         carry2, ovf2, busy2, done2;

  serial_addsub_chunked dut0 (
    .clk(clk), .reset(reset), .start(start0), .sub(sub0), .A(a0), .B(b0),
    .S(s0), .carry(carry0), .overflow(ovf0), .busy(busy0), .done(done0)
  );

  serial_addsub_chunked #(.WIDTH(64), .CHUNK(24)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .sub(sub1), .A(a1), .B(b1),
    .S(s1), .carry(carry1), .overflow(ovf1), .busy(busy1), .done(done1)
  );

  serial_addsub_chunked #(.WIDTH(8), .CHUNK(8)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .sub(sub2), .A(a2), .B(b2),
    .S(s2), .carry(carry2), .overflow(ovf2), .busy(busy2), .done(done2)
  );

  int tests = 0;
  int fails = 0;
  int lat;
  int done_seen;

  logic [380:0] ones381;
  logic [380:0] p380;

  task automatic check(input string tag, input logic [380:0] obs,
                       input logic [380:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One op on dut0; returns edges from accept edge until done seen high.
  task automatic op0(input logic s, input logic [380:0] a, input logic [380:0] b,
                     output int l);
    @(negedge clk);
    sub0 = s; a0 = a; b0 = b; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    l = 0;
    while (!done0 && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic op1(input logic s, input logic [63:0] a, input logic [63:0] b,
                     output int l);
    @(negedge clk);
    sub1 = s; a1 = a; b1 = b; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    l = 0;
    while (!done1 && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    ones381 = '1;
    p380    = 381'(1) << 380;
    reset  = 1'b0;
    start0 = 0; sub0 = 0; a0 = '0; b0 = '0;
    start1 = 0; sub1 = 0; a1 = '0; b1 = '0;
    start2 = 0; sub2 = 0; a2 = '0; b2 = '0;

    // Reset state
    #12;
    check("rst_S", s0, '0);
    check("rst_carry", 381'(carry0), 381'(0));
    check("rst_ovf", 381'(ovf0), 381'(0));
    check("rst_busy", 381'(busy0), 381'(0));
    check("rst_done", 381'(done0), 381'(0));
    check("rst_S64", 381'(s1), 381'(0));
    @(negedge clk);
    reset = 1'b1;

    // 1: all-ones + 1 wraps to zero with carry out
    op0(1'b0, ones381, 381'(1), lat);
    check("t1_lat", 381'(lat), 381'(12));
    check("t1_S", s0, '0);
    check("t1_carry", 381'(carry0), 381'(1));
    check("t1_ovf", 381'(ovf0), 381'(0));
    check("t1_busy_at_done", 381'(busy0), 381'(0));
    @(posedge clk); #1;
    check("t1_done_low", 381'(done0), 381'(0));
    check("t1_S_hold", s0, '0);

    // 2: subtract with and without borrow
    op0(1'b1, 381'(5), 381'(7), lat);
    check("t2a_S", s0, ones381 - 381'(1));
    check("t2a_carry", 381'(carry0), 381'(0));
    check("t2a_ovf", 381'(ovf0), 381'(0));
    op0(1'b1, 381'(7), 381'(5), lat);
    check("t2b_S", s0, 381'(2));
    check("t2b_carry", 381'(carry0), 381'(1));

    // 3: signed overflow for add and subtract
    op0(1'b0, p380 - 381'(1), 381'(1), lat);
    check("t3a_S", s0, p380);
    check("t3a_ovf", 381'(ovf0), 381'(1));
    check("t3a_carry", 381'(carry0), 381'(0));
    op0(1'b1, p380, 381'(1), lat);
    check("t3b_S", s0, p380 - 381'(1));
    check("t3b_ovf", 381'(ovf0), 381'(1));
    check("t3b_carry", 381'(carry0), 381'(1));

    // 4: partial last chunk, 64/24
    op1(1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, lat);
    check("t4a_lat", 381'(lat), 381'(3));
    check("t4a_S", 381'(s1), 381'(0));
    check("t4a_carry", 381'(carry1), 381'(1));
    check("t4a_ovf", 381'(ovf1), 381'(1));
    @(posedge clk); #1;
    check("t4a_done_low", 381'(done1), 381'(0));
    op1(1'b1, 64'h0, 64'h0, lat);
    check("t4b_S", 381'(s1), 381'(0));
    check("t4b_carry", 381'(carry1), 381'(1));
    op1(1'b0, 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210, lat);
    check("t4c_S", 381'(s1), 381'(64'hffff_ffff_ffff_ffff));
    check("t4c_carry", 381'(carry1), 381'(0));
    check("t4c_ovf", 381'(ovf1), 381'(0));
    op1(1'b1, 64'h10, 64'h20, lat);
    check("t4d_S", 381'(s1), 381'(64'hffff_ffff_ffff_fff0));
    check("t4d_carry", 381'(carry1), 381'(0));

    // Single-chunk instance: 0x7f + 1
    @(negedge clk);
    sub2 = 1'b0; a2 = 8'h7f; b2 = 8'h01; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t8_lat", 381'(lat), 381'(1));
    check("t8_S", 381'(s2), 381'(8'h80));
    check("t8_ovf", 381'(ovf2), 381'(1));
    check("t8_carry", 381'(carry2), 381'(0));

    // 5: start during RUN ignored; start held through DONE accepted
    @(negedge clk);
    sub0 = 1'b0; a0 = 381'(3); b0 = 381'(4); start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sub0 = 1'b1; a0 = 381'(10); b0 = 381'(1); start0 = 1'b1;
    lat = 3;
    while (!done0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t5a_lat", 381'(lat), 381'(12));
    check("t5a_S", s0, 381'(7));
    check("t5a_carry", 381'(carry0), 381'(0));
    @(posedge clk); #1;
    check("t5b_busy", 381'(busy0), 381'(1));
    check("t5b_done", 381'(done0), 381'(0));
    start0 = 1'b0;
    lat = 0;
    while (!done0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t5b_lat", 381'(lat), 381'(12));
    check("t5b_S", s0, 381'(9));
    check("t5b_carry", 381'(carry0), 381'(1));

    // 6: asynchronous reset mid-RUN
    @(negedge clk);
    sub0 = 1'b0; a0 = ones381; b0 = '0; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("t6_partial_S", 381'(s0[31:0]), 381'(32'hffff_ffff));
    reset = 1'b0;
    #1;
    check("t6_busy", 381'(busy0), 381'(0));
    check("t6_S", s0, '0);
    check("t6_carry", 381'(carry0), 381'(0));
    done_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done0) done_seen++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done0) done_seen++;
    end
    check("t6_no_done", 381'(done_seen), 381'(0));
    op0(1'b1, 381'(7), 381'(5), lat);
    check("t6_lat", 381'(lat), 381'(12));
    check("t6_S_after", s0, 381'(2));
    check("t6_carry_after", 381'(carry0), 381'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
